// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store lane enables/replication, load extraction/extension,
// and access legality checks.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   addr_lo,
    input  logic [2:0]   funct3,
    input  logic         we,
    input  logic [W-1:0] wdata,
    input  logic [W-1:0] rdata,
    output logic [3:0]   be,
    output logic [W-1:0] wdata_rep,
    output logic [W-1:0] rdata_ext,
    output logic         misaligned,
    output logic         illegal
);

    logic [W-1:0]       shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                be         = 4'b1111;
                wdata_rep  = wdata;
                misaligned = |addr_lo;
            end
        endcase
    end

    // Stores only exist for B/H/W; loads add BU/HU.
    assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && we);

    assign shifted = rdata >> {addr_lo, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];

    always_comb begin
        rdata_ext = '0;
        case (funct3)
            LB:      rdata_ext = {{(W-8){byte_s[7]}}, byte_s};
            LH:      rdata_ext = {{(W-16){half_s[15]}}, half_s};
            LW:      rdata_ext = shifted;
            LBU:     rdata_ext = {{(W-8){1'b0}}, shifted[7:0]};
            LHU:     rdata_ext = {{(W-16){1'b0}}, shifted[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit bridging the pipeline to a gnt/rvalid
// memory port.
module lsu
    import lsu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lsu_valid,
    output logic         lsu_ready,
    input  logic [W-1:0] lsu_addr,
    input  logic [W-1:0] lsu_wdata,
    input  logic         lsu_we,
    input  logic [2:0]   lsu_funct3,
    output logic [W-1:0] lsu_rdata,
    output logic         lsu_done,
    output logic         lsu_err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [3:0]   mem_be,
    output logic [W-1:0] mem_wdata,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [W-1:0] mem_rdata
);

    lsu_state_e   state, state_nxt;
    logic [W-1:0] addr_q, wdata_q, rdata_q;
    logic [2:0]   funct3_q;
    logic         we_q, err_q;

    logic         in_idle, accept, acc_err;
    logic [1:0]   addr_sel;
    logic [2:0]   funct3_sel;
    logic         we_sel;
    logic [3:0]   be;
    logic [W-1:0] wdata_rep, rdata_ext;
    logic         misaligned, illegal;

    assign in_idle = (state == IDLE);
    assign accept  = in_idle && lsu_valid;

    // Legality must be judged on the live request in IDLE, on the held copy afterwards.
    assign addr_sel   = in_idle ? lsu_addr[1:0] : addr_q[1:0];
    assign funct3_sel = in_idle ? lsu_funct3    : funct3_q;
    assign we_sel     = in_idle ? lsu_we        : we_q;
    assign acc_err    = misaligned || illegal;

    lsu_align #(.W(W)) u_align (
        .addr_lo    (addr_sel),
        .funct3     (funct3_sel),
        .we         (we_sel),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lsu_valid) state_nxt = acc_err ? RESP : REQ;
            REQ:     if (mem_gnt) state_nxt = we_q ? RESP : WAIT;
            WAIT:    if (mem_rvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request payload; visibility is gated by the state, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= lsu_addr;
            wdata_q  <= lsu_wdata;
            we_q     <= lsu_we;
            funct3_q <= lsu_funct3;
            err_q    <= acc_err;
            rdata_q  <= '0;
        end else if (state == WAIT && mem_rvalid) begin
            rdata_q <= rdata_ext;
        end
    end

    always_comb begin
        lsu_ready = 1'b0;
        lsu_done  = 1'b0;
        lsu_err   = 1'b0;
        lsu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        mem_addr  = '0;
        case (state)
            IDLE: lsu_ready = 1'b1;
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = be;
                mem_wdata = wdata_rep;
                mem_addr  = {addr_q[W-1:2], 2'b00};
            end
            RESP: begin
                lsu_done  = 1'b1;
                lsu_err   = err_q;
                lsu_rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver pushes modelled expectations, a negedge
// monitor compares memory-side requests and completions.
module tb_lsu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lsu_valid = 1'b0;
    logic         lsu_ready;
    logic [W-1:0] lsu_addr = '0;
    logic [W-1:0] lsu_wdata = '0;
    logic         lsu_we = 1'b0;
    logic [2:0]   lsu_funct3 = 3'b000;
    logic [W-1:0] lsu_rdata;
    logic         lsu_done;
    logic         lsu_err;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [3:0]   mem_be;
    logic [W-1:0] mem_wdata;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    lsu #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_rdata  (lsu_rdata),
        .lsu_done   (lsu_done),
        .lsu_err    (lsu_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        we;
    } exp_t;

    exp_t resp_q[$];
    exp_t mem_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: access size, lane offset and extension from plain arithmetic.
    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                                   input logic [2:0] f3, input logic [31:0] word, input int gd,
                                   input int rd);
        exp_t   e;
        int     size, off, bits;
        logic   legal;
        longint v;
        off  = int'(addr % 32'd4);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        e.err   = !legal || ((off % size) != 0);
        e.maddr = addr - 32'(off);
        e.we    = we;
        e.be    = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = wd[8*(i % size) +: 8];
        bits = 8 * size;
        v = longint'(word >> (8 * off)) & ((longint'(1) << bits) - 1);
        if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        e.rdata = (we || e.err) ? 32'd0 : 32'(v);
        e.lat   = e.err ? 1 : (we ? 2 + gd : 3 + gd + rd);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", 64'(mem_req), 64'(0));
                end else begin
                    check("mem_addr", 64'(mem_addr), 64'(mem_q[0].maddr));
                    check("mem_be", 64'(mem_be), 64'(mem_q[0].be));
                    check("mem_we", 64'(mem_we), 64'(mem_q[0].we));
                    if (mem_q[0].we) check("mem_wdata", 64'(mem_wdata), 64'(mem_q[0].mwdata));
                    if (mem_gnt) void'(mem_q.pop_front());
                end
            end else begin
                check("idle_be_we", 64'({mem_be, mem_we}), 64'(0));
            end
            if (lsu_valid && lsu_ready) acc_q.push_back(cyc);
            if (lsu_done) begin
                if (resp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_done", 64'(lsu_done), 64'(0));
                end else begin
                    exp_t e;
                    int   a;
                    e = resp_q.pop_front();
                    a = acc_q.pop_front();
                    check("lsu_err", 64'(lsu_err), 64'(e.err));
                    check("lsu_rdata", 64'(lsu_rdata), 64'(e.rdata));
                    check("latency", 64'(cyc - a), 64'(e.lat));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({lsu_ready, mem_req, lsu_done, lsu_err, mem_we, mem_be}),
              64'(9'b1_0000_0000));
        check({tag, "_data"}, 64'(lsu_rdata | mem_wdata | mem_addr), 64'(0));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!lsu_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 30) begin
            check("idle_timeout", 64'(lsu_ready), 64'(1));
            do_reset();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lsu_valid = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        resp_q.delete();
        mem_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issues one request and plays the memory side; called at posedge+1.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                           input logic [2:0] f3, input logic [31:0] word, input int gd,
                           input int rd);
        exp_t e;
        e = model(addr, wd, we, f3, word, gd, rd);
        resp_q.push_back(e);
        if (!e.err) mem_q.push_back(e);
        lsu_valid  = 1'b1;
        lsu_addr   = addr;
        lsu_wdata  = wd;
        lsu_we     = we;
        lsu_funct3 = f3;
        @(posedge clk); #1;
        lsu_valid  = 1'b0;
        lsu_addr   = $urandom;
        lsu_wdata  = $urandom;
        lsu_we     = 1'($urandom_range(0, 1));
        lsu_funct3 = 3'($urandom_range(0, 7));
        if (!e.err) begin
            repeat (gd) begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b1;
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            if (!we) begin
                repeat (rd) begin
                    mem_rdata = $urandom;
                    @(posedge clk); #1;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = word;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
        wait_idle();
    endtask

    task automatic reset_in_wait();
        exp_t e;
        e = model(32'h300, 32'h0, 1'b0, 3'b010, 32'h0, 0, 0);
        mem_q.push_back(e);
        lsu_valid  = 1'b1;
        lsu_addr   = 32'h300;
        lsu_we     = 1'b0;
        lsu_funct3 = 3'b010;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("busy_in_wait", 64'(lsu_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_wait");
        resp_q.delete();
        mem_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("late_rvalid_done", 64'(lsu_done), 64'(0));
            check("late_rvalid_ready", 64'(lsu_ready), 64'(1));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(32'h100, 32'hDEADBEEF, 1'b1, 3'b010, 32'h0, 0, 0);
        run_txn(32'h103, 32'h000000A5, 1'b1, 3'b000, 32'h0, 0, 0);
        run_txn(32'h202, 32'h0, 1'b0, 3'b000, 32'h1280FF34, 0, 0);
        run_txn(32'h202, 32'h0, 1'b0, 3'b100, 32'h1280FF34, 0, 0);
        run_txn(32'h201, 32'h0, 1'b0, 3'b001, 32'h0, 0, 0);
        run_txn(32'h400, 32'h0, 1'b0, 3'b010, 32'h89ABCDEF, 4, 0);
        run_txn(32'h502, 32'h0000F00D, 1'b1, 3'b001, 32'h0, 1, 0);
        run_txn(32'h506, 32'h0, 1'b0, 3'b101, 32'h80017FFE, 0, 2);
        run_txn(32'h504, 32'h0, 1'b1, 3'b100, 32'h0, 0, 0);

        reset_in_wait();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_txn(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        check("pending_resp", 64'(resp_q.size()), 64'(0));
        check("pending_mem", 64'(mem_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
